// File: rtl/xbus_pkg.sv
// Shared xbus definitions: default bus geometry, bridge FSM encoding and the slave address map
// used by the external decoder.
package xbus_pkg;

  localparam int unsigned XBUS_NSLAVES        = 4;
  localparam int unsigned XBUS_DATA_W         = 32;
  localparam int unsigned XBUS_ADDR_W         = 32;
  localparam int unsigned XBUS_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } xbus_state_e;

  // Slave i owns every address with (addr & MASK[i]) == BASE[i]
  localparam logic [XBUS_ADDR_W-1:0] XBUS_SLV_BASE [XBUS_NSLAVES] =
    '{32'h0000_1000, 32'h8000_0000, 32'h0001_0000, 32'h4000_0000};
  localparam logic [XBUS_ADDR_W-1:0] XBUS_SLV_MASK [XBUS_NSLAVES] =
    '{32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  function automatic logic [XBUS_NSLAVES-1:0] xbus_decode(input logic [XBUS_ADDR_W-1:0] addr);
    logic [XBUS_NSLAVES-1:0] cs;
    cs = '0;
    for (int i = 0; i < int'(XBUS_NSLAVES); i++) begin
      cs[i] = ((addr & XBUS_SLV_MASK[i]) == XBUS_SLV_BASE[i]);
    end
    return cs;
  endfunction

endpackage

// File: rtl/xbus_resp_mux.sv
// One-hot response mux: picks the selected slave's ack/read data and flags empty or
// overlapping chip selects.
module xbus_resp_mux #(
  parameter int unsigned NSLAVES = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic [NSLAVES-1:0]        xbus_cs,
  input  logic [NSLAVES*DATA_W-1:0] xbus_rdata,
  input  logic [NSLAVES-1:0]        xbus_ack,
  output logic                      sel_ack,
  output logic [DATA_W-1:0]         sel_rdata,
  output logic                      cs_none,
  output logic                      cs_multi
);

  logic seen;

  // AND-OR mux; results are only meaningful when exactly one select is set
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    seen      = 1'b0;
    cs_multi  = 1'b0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      if (xbus_cs[i]) begin
        if (seen) begin
          cs_multi = 1'b1;
        end
        seen      = 1'b1;
        sel_ack   = sel_ack | xbus_ack[i];
        sel_rdata = sel_rdata | xbus_rdata[i*DATA_W +: DATA_W];
      end
    end
    cs_none = ~seen;
  end

endmodule

// File: rtl/xbus_master_bridge.sv
// CPU-side xbus master: one outstanding load/store, IDLE -> BUS -> RESP.
// Define XBUS_TIMEOUT_EN to turn a slave that never acks into a bus error.
module xbus_master_bridge
  import xbus_pkg::*;
#(
  parameter int unsigned NSLAVES = XBUS_NSLAVES,
  parameter int unsigned DATA_W  = XBUS_DATA_W
`ifdef XBUS_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = XBUS_TIMEOUT_CYCLES
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [XBUS_ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic [DATA_W/8-1:0]       cpu_be,
  output logic                      cpu_ready,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_err,
  output logic                      xbus_as,
  output logic [XBUS_ADDR_W-1:0]    xbus_addr,
  output logic                      xbus_we,
  output logic [DATA_W-1:0]         xbus_wdata,
  output logic [DATA_W/8-1:0]       xbus_be,
  input  logic [NSLAVES-1:0]        xbus_cs,
  input  logic [NSLAVES*DATA_W-1:0] xbus_rdata,
  input  logic [NSLAVES-1:0]        xbus_ack
);

  localparam int unsigned BE_W = DATA_W / 8;

  xbus_state_e              state_q, state_d;
  logic                     as_q, as_d;
  logic [XBUS_ADDR_W-1:0]   addr_q, addr_d;
  logic                     we_q, we_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [BE_W-1:0]          be_q, be_d;
  logic                     ready_q, ready_d;
  logic                     err_q, err_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;

  logic                     sel_ack;
  logic [DATA_W-1:0]        sel_rdata;
  logic                     cs_none;
  logic                     cs_multi;
  logic                     timeout_c;

  xbus_resp_mux #(
    .NSLAVES (NSLAVES),
    .DATA_W  (DATA_W)
  ) u_resp_mux (
    .xbus_cs    (xbus_cs),
    .xbus_rdata (xbus_rdata),
    .xbus_ack   (xbus_ack),
    .sel_ack    (sel_ack),
    .sel_rdata  (sel_rdata),
    .cs_none    (cs_none),
    .cs_multi   (cs_multi)
  );

`ifdef XBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts the BUS cycles already spent without ack, so the
  // TIMEOUT_CYCLES-th unacked cycle is the one that gives up
  assign timeout_c = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      as_q    <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      as_q    <= as_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    as_d    = as_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ready_d = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef XBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          be_d    = cpu_be;
          as_d    = 1'b1;
          state_d = ST_BUS;
`ifdef XBUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      // Decode errors outrank an ack; an ack outranks the timeout
      ST_BUS: begin
        if (cs_none || cs_multi || (!sel_ack && timeout_c)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          as_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end else if (sel_ack) begin
          rdata_d = we_q ? '0 : sel_rdata;
          as_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end
`ifdef XBUS_TIMEOUT_EN
        else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        as_d    = 1'b0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cpu_ready  = ready_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;
  assign xbus_as    = as_q;
  assign xbus_addr  = addr_q;
  assign xbus_we    = we_q;
  assign xbus_wdata = wdata_q;
  assign xbus_be    = be_q;

endmodule

// File: tb/tb_xbus_master_bridge.sv
// Scoreboard bench for xbus_master_bridge: the bench plays decoder and slaves, predicts every
// response from the transaction plan, and a monitor checks each cpu_ready against the queue.
module tb_xbus_master_bridge;
  import xbus_pkg::*;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TO = XBUS_TIMEOUT_CYCLES;
`ifdef XBUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    int          bus_cycles;
    int          issue_cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cpu_req = 1'b0;
  logic           cpu_we = 1'b0;
  logic [31:0]    cpu_addr = '0;
  logic [31:0]    cpu_wdata = '0;
  logic [3:0]     cpu_be = '0;
  logic           cpu_ready;
  logic [31:0]    cpu_rdata;
  logic           cpu_err;
  logic           xbus_as;
  logic [31:0]    xbus_addr;
  logic           xbus_we;
  logic [31:0]    xbus_wdata;
  logic [3:0]     xbus_be;
  logic [NS-1:0]  xbus_cs;
  logic [NS*DW-1:0] xbus_rdata;
  logic [NS-1:0]  xbus_ack;

  // Slave/decoder plan for the transaction in flight
  int             tgt = -1;
  int             plan_wait = -1;
  logic [NS-1:0]  noise_mask = '0;
  logic [NS-1:0]  ack_ovr = '0;
  logic [NS-1:0]  force_cs = '0;
  logic           force_en = 1'b0;
  logic [31:0]    lane [NS];
  int             bus_cyc = 0;
  int             cyc = 0;

  exp_t           exp_q [$];
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [31:0]    last_rdata = '0;
  int             bus_seen = 0;

  xbus_master_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_be     (cpu_be),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .xbus_as    (xbus_as),
    .xbus_addr  (xbus_addr),
    .xbus_we    (xbus_we),
    .xbus_wdata (xbus_wdata),
    .xbus_be    (xbus_be),
    .xbus_cs    (xbus_cs),
    .xbus_rdata (xbus_rdata),
    .xbus_ack   (xbus_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !xbus_as) bus_cyc <= 0;
    else                 bus_cyc <= bus_cyc + 1;
  end

  // Decoder and slave lanes; noise lanes ack every cycle with all-ones data
  always_comb begin
    if (force_en)     xbus_cs = force_cs;
    else if (xbus_as) xbus_cs = xbus_decode(xbus_addr);
    else              xbus_cs = '0;
    xbus_ack = noise_mask | ack_ovr;
    if (xbus_as && tgt >= 0 && plan_wait >= 0 && bus_cyc == plan_wait)
      xbus_ack = xbus_ack | NS'(1 << tgt);
    xbus_rdata = '0;
    for (int i = 0; i < NS; i++)
      xbus_rdata[i*DW +: DW] = noise_mask[i] ? 32'hFFFF_FFFF : lane[i];
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic finish_sim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Monitor: pops one expected response per cpu_ready, checks bus payload while strobed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rdata = '0;
        bus_seen   = 0;
      end else if (cpu_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 64'(cpu_ready), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rdata", 64'(cpu_rdata), 64'(e.rdata));
          chk("err", 64'(cpu_err), 64'(e.err));
          chk("bus_cycles", 64'(bus_seen), 64'(e.bus_cycles));
          chk("latency", 64'(cyc - e.issue_cyc), 64'(e.bus_cycles + 1));
          chk("as_in_resp", 64'(xbus_as), 64'(0));
          last_rdata = e.rdata;
        end
        bus_seen = 0;
      end else begin
        chk("err_idle", 64'(cpu_err), 64'(0));
        chk("rdata_hold", 64'(cpu_rdata), 64'(last_rdata));
        if (xbus_as) begin
          bus_seen++;
          if (exp_q.size() != 0) begin
            chk("bus_addr", 64'(xbus_addr), 64'(exp_q[0].addr));
            chk("bus_we", 64'(xbus_we), 64'(exp_q[0].we));
            chk("bus_wdata", 64'(xbus_wdata), 64'(exp_q[0].wdata));
            chk("bus_be", 64'(xbus_be), 64'(exp_q[0].be));
          end
        end
      end
    end
  end

  // slv: 0..3 mapped slave, -1 unmapped (cs=0), -2 forced multi-hot mcs; wait_n -1 = never ack
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int slv, input int wait_n,
                        input logic [3:0] noise, input logic [3:0] mcs, input logic [31:0] tdata);
    exp_t e;
    int   guard;
    for (int i = 0; i < NS; i++) lane[i] = $urandom;
    if (slv >= 0) lane[slv] = tdata;
    e.addr  = addr;
    e.we    = we;
    e.wdata = wdata;
    e.be    = be;
    if (slv < 0) begin
      e.err = 1'b1; e.rdata = '0; e.bus_cycles = 1;
    end else if (wait_n < 0 || (TO_EN && wait_n >= TO)) begin
      e.err = 1'b1; e.rdata = '0; e.bus_cycles = TO;
    end else begin
      e.err = 1'b0; e.rdata = we ? 32'h0 : tdata; e.bus_cycles = wait_n + 1;
    end
    tgt        = slv;
    plan_wait  = wait_n;
    force_en   = (slv == -2);
    force_cs   = mcs;
    noise_mask = (slv >= 0) ? (noise & ~NS'(1 << slv)) : noise;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    cpu_be     = be;
    cpu_req    = 1'b1;
    e.issue_cyc = cyc;
    exp_q.push_back(e);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!cpu_ready && guard < 200);
    if (!cpu_ready) begin
      chk("ready_timeout", 64'(cpu_ready), 64'(1));
      finish_sim();
    end
    @(posedge clk); #1;
    cpu_req    = 1'b0;
    tgt        = -1;
    plan_wait  = -1;
    force_en   = 1'b0;
    noise_mask = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          slv, wt, a;
    logic [31:0] addr;
    logic [3:0]  mcs;
    for (int i = 0; i < NS; i++) lane[i] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_as", 64'(xbus_as), 64'(0));
    chk("rst_ready", 64'(cpu_ready), 64'(0));
    chk("rst_err", 64'(cpu_err), 64'(0));
    chk("rst_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_addr", 64'(xbus_addr), 64'(0));
    chk("rst_we", 64'(xbus_we), 64'(0));
    chk("rst_wdata", 64'(xbus_wdata), 64'(0));
    chk("rst_be", 64'(xbus_be), 64'(0));
    @(posedge clk); #1;

    // Directed scenarios
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 1, 0, 4'h0, 4'h0, 32'hDEAD_BEEF);
    do_txn(1'b1, 32'h0001_0000, 32'h0000_0055, 4'hF, 2, 3, 4'h0, 4'h0, 32'h1234_5678);
    do_txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, -1, -1, 4'h0, 4'h0, 32'h0);
    do_txn(1'b0, 32'h8000_0020, 32'h0, 4'h3, 1, 2, 4'b1000, 4'h0, $urandom);
    do_txn(1'b0, 32'h4000_0100, 32'h0, 4'hF, -2, -1, 4'h0, 4'b0110, 32'h0);
    do_txn(1'b0, 32'h0001_0040, 32'h0, 4'hF, 2, TO - 1, 4'h0, 4'h0, 32'hCAFE_F00D);
    do_txn(1'b0, 32'h0001_0044, 32'h0, 4'hF, 2, TO, 4'h0, 4'h0, 32'hA5A5_5A5A);

    // Slave that never acks
    if (TO_EN) begin
      do_txn(1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, -1, 4'h0, 4'h0, 32'h0);
    end else begin
      tgt = 0; plan_wait = -1;
      cpu_we = 1'b0; cpu_addr = 32'h0000_1000; cpu_req = 1'b1;
      repeat (100) @(negedge clk);
      chk("hang_still_bus", 64'(xbus_as), 64'(1));
      @(posedge clk); #1;
      rst = 1'b1; cpu_req = 1'b0; tgt = -1;
      @(posedge clk); #1;
      rst = 1'b0;
    end

    // Reset during the second BUS cycle, then a late ack that must be ignored
    tgt = 0; plan_wait = 5;
    cpu_we = 1'b0; cpu_addr = 32'h0000_1004; cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; tgt = -1; plan_wait = -1; ack_ovr = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_as", 64'(xbus_as), 64'(0));
      chk("post_rst_ready", 64'(cpu_ready), 64'(0));
    end
    @(posedge clk); #1;
    ack_ovr = '0;
    do_txn(1'b0, 32'h8000_0000, 32'h0, 4'hF, 1, 1, 4'h0, 4'h0, 32'h0BAD_F00D);

    // Randomised traffic, back-to-back or with short gaps
    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, 9);
      if (a < 8)       slv = a % 4;
      else if (a == 8) slv = -1;
      else             slv = -2;
      a = $urandom_range(0, 3);
      mcs = 4'(1 << a) | 4'(1 << ((a + 1 + $urandom_range(0, 2)) % 4));
      if (slv >= 0)
        addr = (XBUS_SLV_BASE[slv] | ($urandom & ~XBUS_SLV_MASK[slv])) & 32'hFFFF_FFFC;
      else if (slv == -1)
        addr = 32'h0000_2000 | ($urandom & 32'h0000_0FFC);
      else
        addr = $urandom;
      wt = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(TO - 2, TO + 3);
      do_txn(1'($urandom), addr, $urandom, 4'($urandom), slv, wt, 4'($urandom), mcs, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    finish_sim();
  end

endmodule
